// File: rtl/lc3_memaccess_unit.sv
// lc3_memaccess_unit: LC3 data-memory access stage (LD/ST/LDI/STI).
// Optional per-phase timeout abort: define LC3_MEMACCESS_TIMEOUT_EN.
module lc3_memaccess_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              dmem_en,
  output logic              dmem_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] memout,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic              busy;
  logic              tmo;
  logic [ADDR_W-1:0] ptr_w;

  assign hs    = req_valid && ready_q;
  assign busy  = (state_q == S_PTR) || (state_q == S_ACCESS);
  // Pointer fetched from memory, zero-extended or truncated to ADDR_W.
  assign ptr_w = ADDR_W'(dmem_dout);

`ifdef LC3_MEMACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expires on the wait cycle that would bring the count to TIMEOUT.
  assign tmo = !dmem_ack && (cnt_q == CW'(TIMEOUT - 1));

  // Per-phase wait counter: cleared on phase entry, counts in PTR/ACCESS.
  always_comb begin
    cnt_d = cnt_q;
    if (busy)
      cnt_d = cnt_q + 1'b1;
    if (hs || (state_q == S_PTR && dmem_ack))
      cnt_d = '0;
  end

  // Wait counter register.
  always_ff @(posedge clock) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register plus registered bus/result outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      en_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      memout_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      memout_q <= memout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: indirect modes fetch the pointer first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (hs)
          state_d = req_mode[1] ? S_PTR : S_ACCESS;
        else
          state_d = S_IDLE;
      end
      S_PTR: begin
        if (dmem_ack)
          state_d = S_ACCESS;
        else if (tmo)
          state_d = S_DONE;
      end
      S_ACCESS: begin
        if (dmem_ack || tmo)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields hold between phases.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    din_d    = din_q;
    memout_d = memout_q;
    if (hs) begin
      wr_d   = req_mode[0];
      rd_d   = req_mode[1] | ~req_mode[0];
      addr_d = req_addr;
      if (req_mode[0])
        din_d = req_data;
    end
    if (state_q == S_PTR && dmem_ack) begin
      addr_d = ptr_w;
      rd_d   = ~wr_q;
    end
    if (state_q == S_ACCESS && dmem_ack && !wr_q)
      memout_d = dmem_dout;
    en_d    = (state_d == S_PTR) || (state_d == S_ACCESS);
    done_d  = (state_d == S_DONE);
    err_d   = busy && tmo;
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  assign req_ready = ready_q;
  assign dmem_en   = en_q;
  assign dmem_rd   = rd_q;
  assign dmem_addr = addr_q;
  assign dmem_din  = din_q;
  assign memout    = memout_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lc3_memaccess_unit.sv
// tb_lc3_memaccess_unit: directed + randomized checks of the LC3
// memory access stage against a memory-level reference model.
module tb_lc3_memaccess_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_mode = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          dmem_en, dmem_rd;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_din;
  logic [DW-1:0] dmem_dout = '0;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] memout;
  logic          done, err;

  int n_chk = 0;
  int n_pass = 0;

  lc3_memaccess_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_addr(req_addr), .req_data(req_data),
    .dmem_en(dmem_en), .dmem_rd(dmem_rd),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .dmem_ack(dmem_ack),
    .memout(memout), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Device memory (what the bus actually did) and reference memory.
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } bus_t;
  bus_t bus_log[$];

  bit mute = 0;
  bit noise = 0;
  bit rand_wait = 0;
  int fixed_wait = 0;
  int wait_n = 0;
  int wcnt = 0;
  int unstable = 0;
  logic [AW+DW:0] snap;

  function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : DW'(a ^ 16'h5A5A);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : DW'(a ^ 16'h5A5A);
  endfunction

  // Memory responder with programmable wait states.
  initial forever begin
    @(posedge clock);
    #2;
    if (dmem_en) begin
      if (wcnt == 0)
        snap = {dmem_rd, dmem_addr, dmem_din};
      else if (snap !== {dmem_rd, dmem_addr, dmem_din})
        unstable++;
    end
    if (dmem_en && !mute && wcnt >= wait_n) begin
      dmem_ack = 1'b1;
      dmem_dout = dmem_rd ? dev_rd(dmem_addr) : DW'($urandom);
      if (!dmem_rd)
        dev_mem[dmem_addr] = dmem_din;
      bus_log.push_back('{dmem_rd, dmem_addr, dmem_din});
      wcnt = 0;
      wait_n = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end else begin
      dmem_ack = (!dmem_en && noise) ? 1'($urandom) : 1'b0;
      dmem_dout = DW'($urandom);
      if (dmem_en)
        wcnt++;
      else
        wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wait(input int k);
    fixed_wait = k;
    wait_n = k;
  endtask

  task automatic issue(input logic [1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output bit ok);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    ok = req_ready;
    req_valid = 1'b1;
    req_mode = m;
    req_addr = a;
    req_data = d;
    tick();
    req_valid = 1'b0;
    req_mode = 2'($urandom);
    req_addr = AW'($urandom);
    req_data = DW'($urandom);
  endtask

  // lat: cycle (handshake = 0) at which done is seen.
  task automatic wait_done(input int budget, output int lat,
                           output int en_cyc, output bit ok);
    lat = 1;
    en_cyc = 0;
    while (!done && lat <= budget) begin
      if (dmem_en)
        en_cyc++;
      tick();
      lat++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({dmem_en, dmem_rd, dmem_addr, dmem_din, memout, done, err, req_ready} !== '0)
      $display("FAIL reset_vals got en=%b rd=%b a=%h d=%h m=%h dn=%b e=%b rdy=%b exp all 0",
               dmem_en, dmem_rd, dmem_addr, dmem_din, memout, done, err, req_ready);
    else n_pass++;
    reset = 1'b1;
    n_chk++;
    if (req_ready !== 1'b0)
      $display("FAIL reset_ready_held got %b exp 0", req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (req_ready !== 1'b1)
      $display("FAIL reset_ready_release got %b exp 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_load();
    int lat, enc;
    bit ok;
    dev_mem[16'h3000] = 16'hBEEF;
    set_wait(0);
    issue(2'b00, 16'h3000, 16'h0, ok);
    n_chk++;
    if ({dmem_en, dmem_rd, dmem_addr} !== {1'b1, 1'b1, 16'h3000})
      $display("FAIL load_bus got en=%b rd=%b a=%h exp 1 1 3000", dmem_en, dmem_rd, dmem_addr);
    else n_pass++;
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (lat !== 2 || !ok)
      $display("FAIL load_latency got %0d exp 2", lat);
    else n_pass++;
    n_chk++;
    if (memout !== 16'hBEEF || err !== 1'b0)
      $display("FAIL load_memout got %h err=%b exp beef err=0", memout, err);
    else n_pass++;
    tick();
    n_chk++;
    if (done !== 1'b0)
      $display("FAIL load_done_pulse got %b exp 0", done);
    else n_pass++;
  endtask

  task automatic test_store();
    int lat, enc;
    bit ok;
    set_wait(3);
    unstable = 0;
    issue(2'b01, 16'h4010, 16'h1234, ok);
    n_chk++;
    if ({dmem_en, dmem_rd, dmem_addr, dmem_din} !== {1'b1, 1'b0, 16'h4010, 16'h1234})
      $display("FAIL store_bus got en=%b rd=%b a=%h d=%h exp 1 0 4010 1234",
               dmem_en, dmem_rd, dmem_addr, dmem_din);
    else n_pass++;
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (enc !== 4 || lat !== 5 || !ok)
      $display("FAIL store_wait got en_cycles=%0d lat=%0d exp 4 5", enc, lat);
    else n_pass++;
    n_chk++;
    if (memout !== 16'hBEEF || unstable !== 0)
      $display("FAIL store_memout got %h unstable=%0d exp beef 0", memout, unstable);
    else n_pass++;
    n_chk++;
    if (dev_rd(16'h4010) !== 16'h1234)
      $display("FAIL store_mem got %h exp 1234", dev_rd(16'h4010));
    else n_pass++;
    set_wait(0);
  endtask

  task automatic test_indirect();
    int lat, enc;
    bit ok;
    dev_mem[16'h2000] = 16'h5555;
    dev_mem[16'h5555] = 16'h00A5;
    set_wait(0);
    bus_log.delete();
    issue(2'b10, 16'h2000, 16'h0, ok);
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (lat !== 3 || !ok)
      $display("FAIL ldi_latency got %0d exp 3", lat);
    else n_pass++;
    n_chk++;
    if (memout !== 16'h00A5)
      $display("FAIL ldi_memout got %h exp 00a5", memout);
    else n_pass++;
    n_chk++;
    if (bus_log.size() !== 2)
      $display("FAIL ldi_phases got %0d exp 2", bus_log.size());
    else if (bus_log[0].a !== 16'h2000 || bus_log[1].a !== 16'h5555 ||
             !bus_log[0].rd || !bus_log[1].rd)
      $display("FAIL ldi_addrs got %h %h exp 2000 5555", bus_log[0].a, bus_log[1].a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, enc;
    bit ok;
    set_wait(0);
    issue(2'b01, 16'h4100, 16'h7777, ok);
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (lat !== 2 || req_ready !== 1'b1)
      $display("FAIL b2b_first got lat=%0d rdy=%b exp 2 1", lat, req_ready);
    else n_pass++;
    issue(2'b00, 16'h4100, 16'h0, ok);
    n_chk++;
    if ({dmem_en, dmem_rd, dmem_addr, done} !== {1'b1, 1'b1, 16'h4100, 1'b0})
      $display("FAIL b2b_bus got en=%b rd=%b a=%h dn=%b exp 1 1 4100 0",
               dmem_en, dmem_rd, dmem_addr, done);
    else n_pass++;
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (lat !== 2 || memout !== 16'h7777)
      $display("FAIL b2b_second got lat=%0d m=%h exp 2 7777", lat, memout);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int lat, enc;
    bit ok;
    bit seen;
    mute = 1;
    issue(2'b11, 16'h6000, 16'hDEAD, ok);
    n_chk++;
    if ({dmem_en, dmem_rd, dmem_addr} !== {1'b1, 1'b1, 16'h6000})
      $display("FAIL rst_ptr_bus got en=%b rd=%b a=%h exp 1 1 6000", dmem_en, dmem_rd, dmem_addr);
    else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_chk++;
    if ({dmem_en, memout, done, req_ready, dmem_addr} !== '0)
      $display("FAIL rst_mid got en=%b m=%h dn=%b rdy=%b a=%h exp 0",
               dmem_en, memout, done, req_ready, dmem_addr);
    else n_pass++;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done)
        seen = 1;
    end
    n_chk++;
    if (seen || req_ready !== 1'b1)
      $display("FAIL rst_no_done got done_seen=%b rdy=%b exp 0 1", seen, req_ready);
    else n_pass++;
    mute = 0;
    set_wait(1);
    issue(2'b00, 16'h3000, 16'h0, ok);
    wait_done(20, lat, enc, ok);
    n_chk++;
    if (lat !== 3 || memout !== 16'hBEEF)
      $display("FAIL rst_fresh_load got lat=%0d m=%h exp 3 beef", lat, memout);
    else n_pass++;
    set_wait(0);
  endtask

  task automatic test_timeout();
    int lat, enc;
    bit ok;
    mute = 1;
    issue(2'b00, 16'h7000, 16'h0, ok);
    wait_done(100, lat, enc, ok);
`ifdef LC3_MEMACCESS_TIMEOUT_EN
    n_chk++;
    if (!ok || enc !== TO || lat !== TO + 1)
      $display("FAIL tmo_wait got ok=%b en=%0d lat=%0d exp 1 %0d %0d", ok, enc, lat, TO, TO + 1);
    else n_pass++;
    n_chk++;
    if (err !== 1'b1 || memout !== 16'hBEEF)
      $display("FAIL tmo_err got err=%b m=%h exp 1 beef", err, memout);
    else n_pass++;
    tick();
    n_chk++;
    if (err !== 1'b0 || done !== 1'b0)
      $display("FAIL tmo_pulse got err=%b dn=%b exp 0 0", err, done);
    else n_pass++;
`else
    n_chk++;
    if (ok || dmem_en !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL notmo_busy got done=%b en=%b rdy=%b exp 0 1 0", ok, dmem_en, req_ready);
    else n_pass++;
    n_chk++;
    if (err !== 1'b0 || memout !== 16'hBEEF)
      $display("FAIL notmo_err got err=%b m=%h exp 0 beef", err, memout);
    else n_pass++;
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    mute = 0;
  endtask

  task automatic test_random();
    int lat, enc, bad;
    bit ok, hs_ok;
    logic [1:0]    m;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_m;
    ref_mem = dev_mem;
    noise = 1;
    rand_wait = 1;
    unstable = 0;
    bad = 0;
    exp_m = memout;
    for (int i = 0; i < 200; i++) begin
      m = 2'($urandom);
      a = 16'h1000 + AW'($urandom_range(0, 15));
      d = ($urandom % 2) ? 16'h1000 + DW'($urandom_range(0, 15)) : DW'($urandom);
      case (m)
        2'b00: exp_m = ref_rd(a);
        2'b01: ref_mem[a] = d;
        2'b10: exp_m = ref_rd(ref_rd(a));
        default: ref_mem[ref_rd(a)] = d;
      endcase
      issue(m, a, d, hs_ok);
      wait_done(40, lat, enc, ok);
      if (!hs_ok || !ok || err !== 1'b0 || memout !== exp_m) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_op%0d mode=%b a=%h got m=%h ok=%b err=%b exp m=%h",
                   i, m, a, memout, ok, err, exp_m);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    n_chk++;
    if (bad !== 0)
      $display("FAIL rand_ops got %0d bad ops exp 0", bad);
    else n_pass++;
    bad = 0;
    foreach (ref_mem[k])
      if (!dev_mem.exists(k) || dev_mem[k] !== ref_mem[k])
        bad++;
    n_chk++;
    if (bad !== 0 || dev_mem.size() !== ref_mem.size())
      $display("FAIL rand_mem got %0d diffs sizes %0d/%0d exp 0", bad,
               dev_mem.size(), ref_mem.size());
    else n_pass++;
    n_chk++;
    if (unstable !== 0)
      $display("FAIL rand_bus_stable got %0d changes exp 0", unstable);
    else n_pass++;
    noise = 0;
    rand_wait = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_indirect();
    test_back_to_back();
    test_reset_midop();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_unit.md
# lc3_memaccess_unit

Parametrised data-memory access stage for the LC3 pipeline, successor to the fixed 16-bit single-cycle memaccess datapath. Accepts one load/store request at a time from execute, drives the data-memory bus (`dmem_addr`/`dmem_din`/`dmem_rd`), tolerates variable memory latency via an acknowledge handshake, and supports two-phase indirect accesses (LDI/STI). The registered `memout` is returned to writeback with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, max wait cycles per memory phase; used only with `LC3_MEMACCESS_TIMEOUT_EN`, must be ≥1
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_mode`  in  2  00 load, 01 store, 10 load-indirect, 11 store-indirect
- `req_addr`  in  ADDR_W  effective address (pointer address for indirect modes)
- `req_data`  in  DATA_W  store data
- `dmem_en`  out  1  bus phase active
- `dmem_rd`  out  1  1 read, 0 write; valid while `dmem_en`
- `dmem_addr`  out  ADDR_W  bus address
- `dmem_din`  out  DATA_W  write data to memory
- `dmem_dout`  in  DATA_W  read data from memory, valid with `dmem_ack`
- `dmem_ack`  in  1  memory completes current phase
- `memout`  out  DATA_W  last load result, registered
- `done`  out  1  one-cycle completion pulse, every mode
- `err`  out  1  one-cycle pulse with `done` on timeout abort

## Operation
- States: IDLE, PTR (indirect pointer read), ACCESS (final read/write), DONE.
- `req_ready` = 1 in IDLE and DONE; handshake = `req_valid && req_ready`. Request fields latched on handshake; inputs ignored otherwise.
- Handshake → PTR for modes 10/11, → ACCESS for 00/01. No handshake in DONE → IDLE.
- PTR: `dmem_en`=1, `dmem_rd`=1, `dmem_addr`=latched address. On `dmem_ack`: pointer ← `dmem_dout[ADDR_W-1:0]`, → ACCESS.
- ACCESS: `dmem_en`=1, `dmem_addr`=latched address or pointer. Read modes: `dmem_rd`=1; on ack `memout` ← `dmem_dout`. Write modes: `dmem_rd`=0, `dmem_din`=latched data; on ack write is complete, `memout` unchanged. On ack → DONE.
- DONE: `dmem_en`=0, `done`=1 for exactly one cycle.
- `dmem_ack` outside PTR/ACCESS is ignored. If `DATA_W` < `ADDR_W`, the pointer is zero-extended.
- `dmem_addr`/`dmem_din`/`dmem_rd` hold their last values when `dmem_en`=0.
- Reset (`reset`=0 at a rising edge), in any state including mid-phase: → IDLE; outputs take reset values on that edge; any pending transaction is discarded, no `done`.
- Reset values: `dmem_en` 0, `dmem_rd` 0, `dmem_addr` 0, `dmem_din` 0, `memout` 0, `done` 0, `err` 0, `req_ready` 0 while reset is held, 1 from the first cycle after release.

## Timing
- All outputs registered; `dmem_en` asserts the cycle after the handshake.
- Ack in the first bus cycle gives: load/store handshake at cycle 0, ACCESS at cycle 1, `done` at cycle 2; indirect PTR at 1, ACCESS at 2, `done` at 3.
- Each wait cycle without ack adds one cycle per phase; the bus holds address/data/`dmem_rd` stable until ack.
- Back-to-back: a handshake in DONE enters PTR/ACCESS the next cycle, giving 1 op per 2 cycles at zero wait.

## Configuration
- `LC3_MEMACCESS_TIMEOUT_EN` defined: a per-phase counter clears on entry to PTR/ACCESS and increments each cycle without ack. On the cycle the counter reaches `TIMEOUT` with no ack: → DONE, and `done` and `err` pulse together. `memout` and pointer are unchanged; the remaining indirect phase is skipped. An ack on the same cycle wins (no error).
- Not defined: no counter; the unit waits indefinitely for ack; `err` is tied 0.

## Test plan
- Load, zero wait: mode 00, addr 0x3000, ack in the first cycle with dout 0xBEEF → `dmem_rd`=1 and addr 0x3000 at cycle 1; `memout`=0xBEEF and `done` at cycle 2.
- Store, 3 wait cycles: mode 01, addr 0x4010, data 0x1234 → `dmem_en`=1, `dmem_rd`=0, `dmem_din`=0x1234 held 4 cycles; `done` follows the ack; `memout` unchanged.
- Load-indirect: addr 0x2000 returns pointer 0x5555, then 0x5555 returns 0x00A5 → bus addresses 0x2000 then 0x5555; `memout`=0x00A5; `done` at cycle 3.
- Back-to-back: store, then a load presented in the DONE cycle → load accepted in DONE; its bus phase starts the next cycle; two `done` pulses 2 cycles apart.
- Reset mid-op: `reset`=0 during the PTR wait of an STI → next cycle `dmem_en`=0, `memout`=0, no `done`; a fresh load after release completes normally.
- Timeout (macro on, TIMEOUT=15): load with no ack → `dmem_en` high for 15 cycles, then `done`=`err`=1 for one cycle, `memout` unchanged; with macro off, the unit is still busy after 100 cycles.
